// File: rtl/cache_bank_rr_arbiter_if.sv
// Requester/bank bundle for cache_bank_rr_arbiter: per-port valid/ready requests, read returns, bank drive.
// slave = arbiter side, master = requesters plus the syncRAM bank.
interface cache_bank_rr_arbiter_if #(
    parameter int NUM_REQ          = 4,
    parameter int NUM_BANK_PORTS   = 2,
    parameter int DATA_WIDTH       = 32,
    parameter int CACHE_ADDR_WIDTH = 8,
    parameter int NET_ADDR_WIDTH   = 8
);
    logic [NUM_REQ-1:0]                         req_valid;
    logic [NUM_REQ-1:0]                         req_ready;
    logic [NUM_REQ-1:0]                         req_we;
    logic [NUM_REQ*CACHE_ADDR_WIDTH-1:0]        req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0]              req_data;
    logic [NUM_REQ*NET_ADDR_WIDTH-1:0]          req_src;
    logic [NUM_REQ-1:0]                         resp_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0]              resp_data;
    logic [NUM_REQ*NET_ADDR_WIDTH-1:0]          resp_src;
    logic [NUM_BANK_PORTS*CACHE_ADDR_WIDTH-1:0] bank_addr;
    logic [NUM_BANK_PORTS*DATA_WIDTH-1:0]       bank_wdata;
    logic [NUM_BANK_PORTS-1:0]                  bank_we;
    logic [NUM_BANK_PORTS-1:0]                  bank_re;
    logic [NUM_BANK_PORTS*DATA_WIDTH-1:0]       bank_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_data, req_src, bank_rdata,
        output req_ready, resp_valid, resp_data, resp_src,
        output bank_addr, bank_wdata, bank_we, bank_re
    );

    modport master (
        output req_valid, req_we, req_addr, req_data, req_src, bank_rdata,
        input  req_ready, resp_valid, resp_data, resp_src,
        input  bank_addr, bank_wdata, bank_we, bank_re
    );
endinterface

// File: rtl/cache_bank_rr_arbiter.sv
// Round-robin scheduler of NUM_REQ request ports onto NUM_BANK_PORTS syncRAM ports; CACHE_ARB_STATS_EN adds conflict_count.
// Latency: handshake -> bank drive 2 cycles; read response READ_LATENCY+1 cycles after bank drive.
// Backpressure: one holding entry per port; req_ready drops while that entry waits for a grant.
module cache_bank_rr_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int NUM_BANK_PORTS   = 2,
    parameter int DATA_WIDTH       = 32,
    parameter int CACHE_ADDR_WIDTH = 8,
    parameter int NET_ADDR_WIDTH   = 8,
    parameter int READ_LATENCY     = 1
) (
    input  logic clk,
    input  logic reset,
`ifdef CACHE_ARB_STATS_EN
    output logic [15:0] conflict_count,
`endif
    cache_bank_rr_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef logic [IDX_W-1:0]            idx_t;
    typedef logic [CACHE_ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0]       data_t;
    typedef logic [NET_ADDR_WIDTH-1:0]   src_t;

    logic [NUM_REQ-1:0] hold_valid, hold_we;
    addr_t              hold_addr [NUM_REQ];
    data_t              hold_data [NUM_REQ];
    src_t               hold_src  [NUM_REQ];
    idx_t               rr_ptr, rr_next;
    logic [NUM_REQ-1:0] grant, ready;
    logic               deferred;

    logic [NUM_BANK_PORTS-1:0] g_vld, g_we;
    addr_t                     g_addr [NUM_BANK_PORTS];
    data_t                     g_data [NUM_BANK_PORTS];
    src_t                      g_src  [NUM_BANK_PORTS];
    idx_t                      g_idx  [NUM_BANK_PORTS];

    logic [NUM_BANK_PORTS-1:0] bank_we_q, bank_re_q;
    addr_t                     bank_addr_q  [NUM_BANK_PORTS];
    data_t                     bank_wdata_q [NUM_BANK_PORTS];
    idx_t                      bank_idx_q   [NUM_BANK_PORTS];
    src_t                      bank_src_q   [NUM_BANK_PORTS];

    logic [NUM_BANK_PORTS-1:0] dl_vld [READ_LATENCY];
    idx_t                      dl_idx [READ_LATENCY][NUM_BANK_PORTS];
    src_t                      dl_src [READ_LATENCY][NUM_BANK_PORTS];

    logic [NUM_REQ-1:0] resp_valid_q;
    data_t              resp_data_q [NUM_REQ];
    src_t               resp_src_q  [NUM_REQ];

    // Scan from rr_ptr; the k-th grant lands on bank port k. Hazarded entries are skipped, not blocking.
    always_comb begin
        int    n_grant;
        int    cur;
        logic  haz;
        logic  c_vld, c_we;
        addr_t c_addr;
        data_t c_data;
        src_t  c_src;
        idx_t  last;

        grant    = '0;
        deferred = 1'b0;
        g_vld    = '0;
        g_we     = '0;
        for (int k = 0; k < NUM_BANK_PORTS; k++) begin
            g_addr[k] = '0;
            g_data[k] = '0;
            g_src[k]  = '0;
            g_idx[k]  = '0;
        end
        n_grant = 0;
        cur     = 0;
        haz     = 1'b0;
        c_vld   = 1'b0;
        c_we    = 1'b0;
        c_addr  = '0;
        c_data  = '0;
        c_src   = '0;
        last    = rr_ptr;

        for (int i = 0; i < NUM_REQ; i++) begin
            cur   = (int'(rr_ptr) + i) % NUM_REQ;
            c_vld = 1'b0;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (j == cur) begin
                    c_vld  = hold_valid[j];
                    c_we   = hold_we[j];
                    c_addr = hold_addr[j];
                    c_data = hold_data[j];
                    c_src  = hold_src[j];
                end
            end
            if (c_vld && n_grant < NUM_BANK_PORTS) begin
                haz = 1'b0;
                for (int k = 0; k < NUM_BANK_PORTS; k++) begin
                    if (k < n_grant && g_addr[k] == c_addr && (g_we[k] || c_we)) begin
                        haz = 1'b1;
                    end
                end
                if (haz) begin
                    deferred = 1'b1;
                end else begin
                    for (int k = 0; k < NUM_BANK_PORTS; k++) begin
                        if (k == n_grant) begin
                            g_vld[k]  = 1'b1;
                            g_we[k]   = c_we;
                            g_addr[k] = c_addr;
                            g_data[k] = c_data;
                            g_src[k]  = c_src;
                            g_idx[k]  = idx_t'(cur);
                        end
                    end
                    for (int j = 0; j < NUM_REQ; j++) begin
                        if (j == cur) begin
                            grant[j] = 1'b1;
                        end
                    end
                    last    = idx_t'(cur);
                    n_grant = n_grant + 1;
                end
            end
        end

        if (n_grant == 0) begin
            rr_next = rr_ptr;
        end else if (int'(last) == NUM_REQ - 1) begin
            rr_next = '0;
        end else begin
            rr_next = last + 1'b1;
        end
    end

    assign ready         = ~hold_valid | grant;
    assign bus.req_ready = ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= '0;
            hold_we    <= '0;
            rr_ptr     <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                hold_addr[i] <= '0;
                hold_data[i] <= '0;
                hold_src[i]  <= '0;
            end
        end else begin
            rr_ptr <= rr_next;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_valid[i] && ready[i]) begin
                    hold_valid[i] <= 1'b1;
                    hold_we[i]    <= bus.req_we[i];
                    hold_addr[i]  <= bus.req_addr[i*CACHE_ADDR_WIDTH +: CACHE_ADDR_WIDTH];
                    hold_data[i]  <= bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                    hold_src[i]   <= bus.req_src[i*NET_ADDR_WIDTH +: NET_ADDR_WIDTH];
                end else if (grant[i]) begin
                    hold_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_we_q <= '0;
            bank_re_q <= '0;
            for (int k = 0; k < NUM_BANK_PORTS; k++) begin
                bank_addr_q[k]  <= '0;
                bank_wdata_q[k] <= '0;
                bank_idx_q[k]   <= '0;
                bank_src_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_BANK_PORTS; k++) begin
                bank_we_q[k]    <= g_vld[k] & g_we[k];
                bank_re_q[k]    <= g_vld[k] & ~g_we[k];
                bank_addr_q[k]  <= g_addr[k];
                bank_wdata_q[k] <= g_we[k] ? g_data[k] : '0;
                bank_idx_q[k]   <= g_idx[k];
                bank_src_q[k]   <= g_src[k];
            end
        end
    end

    // Tag pipeline runs alongside the RAM so its last stage lines up with bank_rdata.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_q <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                dl_vld[s] <= '0;
                for (int k = 0; k < NUM_BANK_PORTS; k++) begin
                    dl_idx[s][k] <= '0;
                    dl_src[s][k] <= '0;
                end
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                resp_data_q[j] <= '0;
                resp_src_q[j]  <= '0;
            end
        end else begin
            dl_vld[0] <= bank_re_q;
            for (int k = 0; k < NUM_BANK_PORTS; k++) begin
                dl_idx[0][k] <= bank_idx_q[k];
                dl_src[0][k] <= bank_src_q[k];
            end
            for (int s = 1; s < READ_LATENCY; s++) begin
                dl_vld[s] <= dl_vld[s-1];
                for (int k = 0; k < NUM_BANK_PORTS; k++) begin
                    dl_idx[s][k] <= dl_idx[s-1][k];
                    dl_src[s][k] <= dl_src[s-1][k];
                end
            end
            resp_valid_q <= '0;
            for (int k = 0; k < NUM_BANK_PORTS; k++) begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (dl_vld[READ_LATENCY-1][k] && int'(dl_idx[READ_LATENCY-1][k]) == j) begin
                        resp_valid_q[j] <= 1'b1;
                        resp_data_q[j]  <= bus.bank_rdata[k*DATA_WIDTH +: DATA_WIDTH];
                        resp_src_q[j]   <= dl_src[READ_LATENCY-1][k];
                    end
                end
            end
        end
    end

`ifdef CACHE_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_count <= '0;
        end else if (deferred && conflict_count != 16'hFFFF) begin
            conflict_count <= conflict_count + 16'd1;
        end
    end
`endif

    assign bus.bank_we    = bank_we_q;
    assign bus.bank_re    = bank_re_q;
    assign bus.resp_valid = resp_valid_q;

    for (genvar k = 0; k < NUM_BANK_PORTS; k++) begin : g_bank
        assign bus.bank_addr[k*CACHE_ADDR_WIDTH +: CACHE_ADDR_WIDTH] = bank_addr_q[k];
        assign bus.bank_wdata[k*DATA_WIDTH +: DATA_WIDTH]            = bank_wdata_q[k];
    end

    for (genvar j = 0; j < NUM_REQ; j++) begin : g_resp
        assign bus.resp_data[j*DATA_WIDTH +: DATA_WIDTH]        = resp_data_q[j];
        assign bus.resp_src[j*NET_ADDR_WIDTH +: NET_ADDR_WIDTH] = resp_src_q[j];
    end
endmodule

// File: doc/cache_bank_rr_arbiter.md
Name: cache_bank_rr_arbiter

Overview:
Parametrised successor to the fixed four-port cache access arbiter. It accepts read and write requests from NUM_REQ network ports (N, S, E, W, and more when the mesh radix grows) and schedules them onto the NUM_BANK_PORTS ports of a synchronous cache bank (syncRAM).
- Round-robin fairness.
- Same-cycle address-hazard deferral.
- Per-port valid/ready back-pressure.
- Tags each read with its requester network address and returns the data and tag to the issuing port after the RAM latency.

Parameters:
NUM_REQ, 4, number of requester ports; index 0=NORTH, 1=SOUTH, 2=EAST, 3=WEST, higher indices for extra ports
NUM_BANK_PORTS, 2, cache bank ports driven per cycle (A, B, ...)
DATA_WIDTH, 32, data word width
CACHE_ADDR_WIDTH, 8, cache bank address width
NET_ADDR_WIDTH, 8, requester network address width
READ_LATENCY, 1, cycles from a bank read address being presented to bank_rdata being valid; must be >= 1

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  request present, one bit per port
req_ready  out  NUM_REQ  port can accept a request this cycle
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*CACHE_ADDR_WIDTH  cache address; port i occupies slice i
req_data  in  NUM_REQ*DATA_WIDTH  write data
req_src  in  NUM_REQ*NET_ADDR_WIDTH  requester network address
resp_valid  out  NUM_REQ  read response valid, one cycle
resp_data  out  NUM_REQ*DATA_WIDTH  read data
resp_src  out  NUM_REQ*NET_ADDR_WIDTH  echoed requester network address
bank_addr  out  NUM_BANK_PORTS*CACHE_ADDR_WIDTH  bank address per bank port
bank_wdata  out  NUM_BANK_PORTS*DATA_WIDTH  bank write data
bank_we  out  NUM_BANK_PORTS  bank write enable
bank_re  out  NUM_BANK_PORTS  bank read enable
bank_rdata  in  NUM_BANK_PORTS*DATA_WIDTH  bank read data

Behaviour:
Request acceptance:
- Each port has a one-entry holding register (valid, we, addr, data, src).
- req_ready[i] = !hold_valid[i] | grant[i] (combinational).
- A handshake loads the holding register at the clock edge.

Arbitration (combinational each cycle):
- Scan held entries starting at rr_ptr, wrapping modulo NUM_REQ.
- Grant at most NUM_BANK_PORTS entries; the k-th grant is assigned to bank port k.
- Hazard rule: skip (defer) an entry whose addr equals that of an entry already granted this cycle, if either of the two is a write. Read/read to the same address is allowed.
- rr_ptr update: set to (last granted index + 1) mod NUM_REQ. Unchanged if no grant.

Bank drive:
- bank_* outputs are registered: a grant in cycle c drives the bank in cycle c+1.
- Ungranted bank ports: we=0, re=0, addr=0, wdata=0.

Timing:
- Request handshake in cycle 0 → earliest bank drive in cycle 2.
- Writes complete at the bank edge; no response is returned for a write.

Read return:
- A delay line of depth READ_LATENCY per bank port carries valid, requester index and src.
- bank_rdata is sampled in cycle c+READ_LATENCY for a read driven in cycle c.
- resp_valid[idx], resp_data and resp_src are registered and appear in cycle c+READ_LATENCY+1 (cycle 4 after the handshake when READ_LATENCY=1).
- Two reads from one port cannot be granted in the same cycle, so their responses never collide.

Reset (synchronous; also applies mid-operation):
- Clears holding registers, delay line, rr_ptr (=0), all bank_* outputs, resp_valid, resp_data and resp_src.
- In-flight reads are dropped; no response is produced for them.
- req_ready = all ones in the cycle after reset deasserts.

Optional Feature:
Macro: CACHE_ARB_STATS_EN
- Defined: adds output port conflict_count (16 bits), reset to 0.
  - Increments by 1 per cycle in which at least one entry was deferred by the hazard rule.
  - Saturates at 16'hFFFF.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset held 2 cycles, then released → all bank_we/bank_re = 0, resp_valid = 0, req_ready = 4'b1111.
- NORTH write addr 0x02, data 10, at cycle 0 → bank port 0: we=1, addr=0x02, wdata=10 in cycle 2; bank port 1 idle.
- NORTH write 0x03 (data 5) and SOUTH write 0x01 (data 4), same cycle, rr_ptr=0 → port 0 = NORTH (addr 0x03), port 1 = SOUTH (addr 0x01), both in the same cycle; rr_ptr becomes 2.
- All four ports request in the same cycle: SOUTH read 0x09 (src 0x21), EAST write 0x05, WEST write 0x04, NORTH write 0x02 → the two bank grants per cycle rotate fairly across the four ports. SOUTH receives resp_valid, the data stored at 0x09 and resp_src=0x21 exactly READ_LATENCY+1 cycles after its bank drive.
- EAST write 0x06 (data 4) and WEST read 0x06 held in the same cycle → only one is granted that cycle; the other is granted the next cycle. WEST's read returns the new value 4 only if the write is granted first. With CACHE_ARB_STATS_EN, conflict_count = 1.
- Reset asserted one cycle after a read reaches the bank → no resp_valid afterwards; the holding registers are empty.
